sram_fifo_ctrl: RTL and testbench
=================================

SRAM_FIFO_CTRL -- requirements
Module: sram_fifo_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, 32, word width matching the 32x256 SRAM macro.
REQ-002 SHALL have parameter ADDR_WIDTH, 8, SRAM address width (256-word storage).
REQ-003 SHALL have port clk  input  1  single clock, rising-edge; also drives SRAM clk0/clk1.
REQ-004 SHALL have port rst  input  1  asynchronous reset, active-high.
REQ-005 SHALL have port flush  input  1  synchronous clear of all FIFO contents.
REQ-006 SHALL have port s_valid  input  1  upstream word available.
REQ-007 SHALL have port s_ready  output  1  FIFO accepts a word this cycle.
REQ-008 SHALL have port s_data  input  DATA_WIDTH  upstream word.
REQ-009 SHALL have port m_valid  output  1  head word available.
REQ-010 SHALL have port m_ready  input  1  downstream takes the head word.
REQ-011 SHALL have port m_data  output  DATA_WIDTH  head word.
REQ-012 SHALL have port sram_csb0  output  1  SRAM port-0 chip select, active-low.
REQ-013 SHALL have port sram_web0  output  1  SRAM port-0 write enable, active-low, tied 0.
REQ-014 SHALL have port sram_wmask0  output  4  SRAM byte mask, tied 4'hF.
REQ-015 SHALL have port sram_addr0  output  ADDR_WIDTH  write address (write pointer).
REQ-016 SHALL have port sram_din0  output  DATA_WIDTH  write data, equals s_data.
REQ-017 SHALL have port sram_csb1  output  1  SRAM port-1 chip select, active-low.
REQ-018 SHALL have port sram_addr1  output  ADDR_WIDTH  read address (read pointer).
REQ-019 SHALL have port sram_dout1  input  DATA_WIDTH  SRAM port-1 read data.

Function
REQ-020 SHALL complete a push on each rising edge with s_valid && s_ready; sram_csb0 = !(s_valid && s_ready) combinationally, addr0 = wr_ptr; wr_ptr increments mod 256.
REQ-021 SHALL track sram_count (0..256, 9 bits) = words in SRAM not yet issued for read; s_ready = !rst && (sram_count != 256).
REQ-022 SHALL hold a 2-entry output buffer; m_valid = buffer non-empty; m_data = buffer head; a pop completes on an edge with m_valid && m_ready.
REQ-023 SHALL issue a read (sram_csb1 = 0, addr1 = rd_ptr) in a cycle iff sram_count != 0 and buffer occupancy plus in-flight reads < 2 after the current pop; rd_ptr increments and sram_count decrements on the issuing edge.
REQ-024 SHALL capture sram_dout1 into the buffer on the edge following the issuing edge (1-cycle SRAM read latency).
REQ-025 SHALL give latency from a push on edge k into an empty FIFO to m_valid high after edge k+2.
REQ-026 SHALL sustain one push and one pop per cycle in steady state, with m_valid never dropping while sram_count != 0.
REQ-027 SHALL never present a port-0 write and a port-1 read to the same address on the same edge; guaranteed since addresses coincide only at sram_count 0 (no read) or 256 (no write).
REQ-028 SHALL give total capacity 258 words (256 SRAM + 2 buffer); simultaneous push and read issue at sram_count 256 are impossible because s_ready is low.
REQ-029 SHALL, on flush sampled high, zero pointers, sram_count and buffer, and discard any in-flight read data; s_ready, m_valid low in the flush cycle; push/pop in that cycle ignored.

Reset
REQ-030 SHALL, while rst is high, force wr_ptr=0, rd_ptr=0, sram_count=0, buffer empty, in-flight flag 0, m_valid=0, s_ready=0, sram_csb0=1, sram_csb1=1, m_data=0.
REQ-031 SHALL discard read data returning after rst asserts mid-operation; SRAM contents are not cleared and are never read back.

Configuration
REQ-032 SHALL, with macro SRAM_FIFO_LEVEL_EN defined, add output port level (9 bits) = sram_count + buffer occupancy + in-flight reads, registered, reset 0; without it, no level port exists and behaviour is otherwise identical.

Verification
REQ-033 SHALL verify single word: push 32'hDEADBEEF at edge k, m_ready=1 -> m_valid high after edge k+2 with m_data=32'hDEADBEEF, sram_csb1 low in cycle k+1.
REQ-034 SHALL verify fill: m_ready=0, push 0..257 -> s_ready low after 258th accept; pops return 0..257 in order, wrap of both pointers.
REQ-035 SHALL verify streaming: 1000 back-to-back pushes of incrementing data, m_ready=1 -> one pop per cycle, no gaps after initial 2-cycle latency, no same-address warning from SRAM model.
REQ-036 SHALL verify backpressure: random m_ready toggling at 50% -> data order and count preserved, buffer never exceeds 2.
REQ-037 SHALL verify flush with read in flight: 10 words stored, flush pulsed -> next cycle m_valid=0, s_ready=1, next push 32'h1 emerges as head.
REQ-038 SHALL verify async reset mid-stream: rst raised between edges -> m_valid, s_ready low immediately, sram_csb0/sram_csb1 high; after release FIFO empty.

Source files
------------

// File: rtl/sram_fifo_ctrl.sv
// sram_fifo_ctrl: FIFO controller that stores words in an external 1RW+1R
// SRAM macro (256 x 32) and keeps a 2-entry output buffer to hide the
// one-cycle SRAM read latency, sustaining one push and one pop per cycle.
// Total capacity is 256 SRAM words plus 2 buffered words.
// Optional build macro: SRAM_FIFO_LEVEL_EN adds a registered 'level' output
// counting every word held (SRAM + buffer + read in flight).
module sram_fifo_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [3:0]            sram_wmask0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  output logic                  sram_csb1,
  output logic [ADDR_WIDTH-1:0] sram_addr1,
  input  logic [DATA_WIDTH-1:0] sram_dout1
`ifdef SRAM_FIFO_LEVEL_EN
  ,
  output logic [ADDR_WIDTH:0]   level
`endif
);

  // SRAM is full when the count reaches 2**ADDR_WIDTH (MSB set, rest zero).
  localparam logic [ADDR_WIDTH:0] FULL_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] ZERO_COUNT = {(ADDR_WIDTH+1){1'b0}};

  logic [ADDR_WIDTH-1:0] wr_ptr_r;
  logic [ADDR_WIDTH-1:0] rd_ptr_r;
  logic [ADDR_WIDTH:0]   sram_count_r;
  logic [DATA_WIDTH-1:0] buf_mem_r [2];
  logic                  buf_head_r;
  logic [1:0]            buf_occ_r;
  logic                  inflight_r;

  logic                  push_s;
  logic                  pop_s;
  logic                  issue_s;
  logic [1:0]            occ_next_s;
  logic                  tail_s;
  logic [ADDR_WIDTH:0]   count_next_s;

  // Handshakes, read-issue decision and SRAM port drive.
  always_comb begin
    s_ready      = !rst && !flush && (sram_count_r != FULL_COUNT);
    m_valid      = !flush && (buf_occ_r != 2'd0);
    m_data       = buf_mem_r[buf_head_r];
    push_s       = s_valid && s_ready;
    pop_s        = m_valid && m_ready;
    // Buffer slots committed after this edge: current occupancy, less the
    // word popped now, plus the word returning from the read in flight.
    occ_next_s   = buf_occ_r + {1'b0, inflight_r} - {1'b0, pop_s};
    issue_s      = !rst && !flush && (sram_count_r != ZERO_COUNT) &&
                   (occ_next_s < 2'd2);
    count_next_s = sram_count_r + {{ADDR_WIDTH{1'b0}}, push_s}
                                - {{ADDR_WIDTH{1'b0}}, issue_s};
    // Returning data lands behind the current head (before any pop shifts it).
    tail_s       = buf_head_r ^ buf_occ_r[0];
    sram_csb0    = !push_s;
    sram_web0    = 1'b0;
    sram_wmask0  = 4'hF;
    sram_addr0   = wr_ptr_r;
    sram_din0    = s_data;
    sram_csb1    = !issue_s;
    sram_addr1   = rd_ptr_r;
  end

  // Pointer, SRAM-count and output-buffer state; flush clears like reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r     <= {ADDR_WIDTH{1'b0}};
      rd_ptr_r     <= {ADDR_WIDTH{1'b0}};
      sram_count_r <= ZERO_COUNT;
      buf_mem_r[0] <= {DATA_WIDTH{1'b0}};
      buf_mem_r[1] <= {DATA_WIDTH{1'b0}};
      buf_head_r   <= 1'b0;
      buf_occ_r    <= 2'd0;
      inflight_r   <= 1'b0;
    end else if (flush) begin
      wr_ptr_r     <= {ADDR_WIDTH{1'b0}};
      rd_ptr_r     <= {ADDR_WIDTH{1'b0}};
      sram_count_r <= ZERO_COUNT;
      buf_mem_r[0] <= {DATA_WIDTH{1'b0}};
      buf_mem_r[1] <= {DATA_WIDTH{1'b0}};
      buf_head_r   <= 1'b0;
      buf_occ_r    <= 2'd0;
      inflight_r   <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (issue_s) begin
        rd_ptr_r <= rd_ptr_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      if (inflight_r) begin
        buf_mem_r[tail_s] <= sram_dout1;
      end else begin
        buf_mem_r[tail_s] <= buf_mem_r[tail_s];
      end
      if (pop_s) begin
        buf_head_r <= ~buf_head_r;
      end else begin
        buf_head_r <= buf_head_r;
      end
      sram_count_r <= count_next_s;
      buf_occ_r    <= occ_next_s;
      inflight_r   <= issue_s;
    end
  end

`ifdef SRAM_FIFO_LEVEL_EN
  logic [ADDR_WIDTH:0] level_r;

  // Registered fill level tracking the post-edge state of every storage stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_r <= ZERO_COUNT;
    end else if (flush) begin
      level_r <= ZERO_COUNT;
    end else begin
      level_r <= count_next_s + {{(ADDR_WIDTH-1){1'b0}}, occ_next_s}
                              + {{ADDR_WIDTH{1'b0}}, issue_s};
    end
  end

  assign level = level_r;
`endif

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Self-checking bench for sram_fifo_ctrl with a behavioural 256x32 SRAM
// (1-cycle read latency) and a queue scoreboard of expected words.
module tb_sram_fifo_ctrl;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic        sram_csb0;
  logic        sram_web0;
  logic [3:0]  sram_wmask0;
  logic [7:0]  sram_addr0;
  logic [31:0] sram_din0;
  logic        sram_csb1;
  logic [7:0]  sram_addr1;
  logic [31:0] sram_dout1;

  int checks;
  int failures;
  int collision_cnt;
  logic [31:0] sb_q [$];
  logic [31:0] mem [256];

  sram_fifo_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_wmask0(sram_wmask0),
    .sram_addr0(sram_addr0), .sram_din0(sram_din0),
    .sram_csb1(sram_csb1), .sram_addr1(sram_addr1), .sram_dout1(sram_dout1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural SRAM: masked write on port 0, registered read on port 1.
  always @(posedge clk) begin
    if (!sram_csb0 && !sram_web0 && sram_wmask0 == 4'hF) mem[sram_addr0] <= sram_din0;
    if (!sram_csb1) sram_dout1 <= mem[sram_addr1];
    if (!sram_csb0 && !sram_csb1 && sram_addr0 == sram_addr1) collision_cnt <= collision_cnt + 1;
  end

  // One cycle: drive inputs on the falling edge, sample outputs 1 time unit later.
  task automatic step(input logic sv, input logic [31:0] sd, input logic mr, input logic fl,
                      output logic acc, output logic pop, output logic [31:0] md);
    @(negedge clk);
    s_valid = sv; s_data = sd; m_ready = mr; flush = fl;
    #1;
    acc = sv && s_ready;
    pop = m_valid && mr;
    md  = m_data;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; s_valid = 1'b0; s_data = 32'h0; m_ready = 1'b0;
    @(negedge clk); @(negedge clk); #1;
    checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL reset_m_valid got=%b exp=0", m_valid); end
    checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL reset_s_ready got=%b exp=0", s_ready); end
    checks++; if (sram_csb0 !== 1'b1) begin failures++; $display("FAIL reset_csb0 got=%b exp=1", sram_csb0); end
    checks++; if (sram_csb1 !== 1'b1) begin failures++; $display("FAIL reset_csb1 got=%b exp=1", sram_csb1); end
    checks++; if (m_data !== 32'h0) begin failures++; $display("FAIL reset_m_data got=%h exp=0", m_data); end
    @(negedge clk); rst = 1'b0; #1;
    checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL reset_release_s_ready got=%b exp=1", s_ready); end
  endtask

  task automatic test_single();
    logic acc, pop; logic [31:0] md;
    step(1'b1, 32'hDEADBEEF, 1'b1, 1'b0, acc, pop, md);   // push completes on edge k
    if (acc) sb_q.push_back(32'hDEADBEEF);
    checks++; if (acc !== 1'b1) begin failures++; $display("FAIL single_accept got=%b exp=1", acc); end
    step(1'b0, 32'h0, 1'b1, 1'b0, acc, pop, md);          // cycle k+1
    checks++; if (sram_csb1 !== 1'b0) begin failures++; $display("FAIL single_read_issue csb1=%b exp=0", sram_csb1); end
    checks++; if (sram_addr1 !== 8'd0) begin failures++; $display("FAIL single_read_addr got=%0d exp=0", sram_addr1); end
    checks++; if (pop !== 1'b0) begin failures++; $display("FAIL single_early_k1 m_valid=%b exp=0", m_valid); end
    step(1'b0, 32'h0, 1'b1, 1'b0, acc, pop, md);          // cycle k+2
    checks++; if (pop !== 1'b0) begin failures++; $display("FAIL single_early_k2 m_valid=%b exp=0", m_valid); end
    step(1'b0, 32'h0, 1'b1, 1'b0, acc, pop, md);          // cycle k+3: head present
    checks++; if (pop !== 1'b1) begin failures++; $display("FAIL single_latency m_valid=%b exp=1", m_valid); end
    if (pop && sb_q.size() > 0) begin
      logic [31:0] exp;
      exp = sb_q.pop_front();
      checks++; if (md !== exp) begin failures++; $display("FAIL single_data got=%h exp=%h", md, exp); end
    end
    step(1'b0, 32'h0, 1'b0, 1'b0, acc, pop, md);
    checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL single_empty_after m_valid=%b exp=0", m_valid); end
    sb_q.delete();
  endtask

  task automatic test_fill();
    logic acc, pop; logic [31:0] md;
    int accepted, popped;
    accepted = 0;
    for (int c = 0; c < 400 && accepted < 258; c++) begin
      step(1'b1, accepted, 1'b0, 1'b0, acc, pop, md);
      if (acc) begin sb_q.push_back(accepted); accepted++; end
    end
    checks++; if (accepted !== 258) begin failures++; $display("FAIL fill_accepted got=%0d exp=258", accepted); end
    step(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, acc, pop, md);
    checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL fill_full_s_ready got=%b exp=0", s_ready); end
    popped = 0;
    for (int c = 0; c < 600 && popped < 258; c++) begin
      step(1'b0, 32'h0, 1'b1, 1'b0, acc, pop, md);
      if (pop) begin
        logic [31:0] exp;
        exp = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hBAD0_BAD0;
        checks++; if (md !== exp) begin failures++; $display("FAIL fill_order got=%h exp=%h", md, exp); end
        popped++;
      end
    end
    checks++; if (popped !== 258) begin failures++; $display("FAIL fill_popped got=%0d exp=258", popped); end
    step(1'b0, 32'h0, 1'b1, 1'b0, acc, pop, md);
    checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL fill_drained m_valid=%b exp=0", m_valid); end
    sb_q.delete();
  endtask

  task automatic test_back_to_back();
    logic acc, pop; logic [31:0] md;
    int pushed, popped, gaps, first_pop, started;
    pushed = 0; popped = 0; gaps = 0; first_pop = -1; started = 0;
    for (int c = 0; c < 1100 && popped < 1000; c++) begin
      step(pushed < 1000, 32'h1000_0000 + pushed, 1'b1, 1'b0, acc, pop, md);
      if (acc) begin sb_q.push_back(32'h1000_0000 + pushed); pushed++; end
      if (pop) begin
        logic [31:0] exp;
        exp = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hBAD0_BAD0;
        checks++; if (md !== exp) begin failures++; $display("FAIL stream_data got=%h exp=%h", md, exp); end
        if (first_pop < 0) first_pop = c;
        started = 1; popped++;
      end else if (started != 0) begin
        gaps++;
      end
    end
    checks++; if (first_pop !== 3) begin failures++; $display("FAIL stream_first_pop cycle=%0d exp=3", first_pop); end
    checks++; if (popped !== 1000) begin failures++; $display("FAIL stream_count got=%0d exp=1000", popped); end
    checks++; if (gaps !== 0) begin failures++; $display("FAIL stream_gaps got=%0d exp=0", gaps); end
    checks++; if (collision_cnt !== 0) begin failures++; $display("FAIL stream_same_addr got=%0d exp=0", collision_cnt); end
    sb_q.delete();
  endtask

  task automatic test_backpressure();
    logic acc, pop; logic [31:0] md;
    int pushed, popped, max_occ;
    pushed = 0; popped = 0; max_occ = 0;
    for (int c = 0; c < 3000 && popped < 300; c++) begin
      step(pushed < 300, 32'hB000_0000 ^ (pushed * 32'h9E37), 1'($urandom_range(0, 1)), 1'b0, acc, pop, md);
      if (int'(dut.buf_occ_r) > max_occ) max_occ = int'(dut.buf_occ_r);
      if (acc) begin sb_q.push_back(32'hB000_0000 ^ (pushed * 32'h9E37)); pushed++; end
      if (pop) begin
        logic [31:0] exp;
        exp = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hBAD0_BAD0;
        checks++; if (md !== exp) begin failures++; $display("FAIL bp_data got=%h exp=%h", md, exp); end
        popped++;
      end
    end
    checks++; if (popped !== 300) begin failures++; $display("FAIL bp_count got=%0d exp=300", popped); end
    checks++; if (max_occ > 2) begin failures++; $display("FAIL bp_buffer_occ got=%0d exp<=2", max_occ); end
    sb_q.delete();
  endtask

  task automatic test_flush();
    logic acc, pop; logic [31:0] md;
    int got;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 32'hF000_0000 + i, 1'b0, 1'b0, acc, pop, md);
      if (acc) sb_q.push_back(32'hF000_0000 + i);
    end
    checks++; if (sb_q.size() !== 10) begin failures++; $display("FAIL flush_stored got=%0d exp=10", sb_q.size()); end
    step(1'b0, 32'h0, 1'b1, 1'b0, acc, pop, md);            // pop one, issues a read
    checks++; if (md !== 32'hF000_0000 || !pop) begin failures++; $display("FAIL flush_pre_pop got=%h exp=f0000000", md); end
    step(1'b1, 32'h7777_7777, 1'b1, 1'b1, acc, pop, md);    // flush cycle, read in flight
    checks++; if (s_ready !== 1'b0 || m_valid !== 1'b0) begin failures++; $display("FAIL flush_cycle s_ready=%b m_valid=%b exp=0,0", s_ready, m_valid); end
    sb_q.delete();
    step(1'b1, 32'h1, 1'b0, 1'b0, acc, pop, md);
    checks++; if (m_valid !== 1'b0 || s_ready !== 1'b1) begin failures++; $display("FAIL flush_after m_valid=%b s_ready=%b exp=0,1", m_valid, s_ready); end
    if (acc) sb_q.push_back(32'h1);
    got = 0;
    for (int c = 0; c < 10 && got == 0; c++) begin
      step(1'b0, 32'h0, 1'b1, 1'b0, acc, pop, md);
      if (pop) begin
        logic [31:0] exp;
        exp = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hBAD0_BAD0;
        checks++; if (md !== exp) begin failures++; $display("FAIL flush_head got=%h exp=%h", md, exp); end
        got = 1;
      end
    end
    checks++; if (got !== 1) begin failures++; $display("FAIL flush_head_timeout got=%0d exp=1", got); end
    step(1'b0, 32'h0, 1'b1, 1'b0, acc, pop, md);
    checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL flush_residue m_valid=%b exp=0", m_valid); end
    sb_q.delete();
  endtask

  task automatic test_async_reset();
    logic acc, pop; logic [31:0] md;
    int pushed, stray, got;
    pushed = 0;
    for (int c = 0; c < 20; c++) begin
      step(1'b1, 32'hC000_0000 + pushed, 1'b1, 1'b0, acc, pop, md);
      if (acc) begin sb_q.push_back(32'hC000_0000 + pushed); pushed++; end
      if (pop) begin
        logic [31:0] exp;
        exp = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hBAD0_BAD0;
        checks++; if (md !== exp) begin failures++; $display("FAIL arst_pre_data got=%h exp=%h", md, exp); end
      end
    end
    @(negedge clk); #2; rst = 1'b1; #1;
    checks++; if (m_valid !== 1'b0 || s_ready !== 1'b0) begin failures++; $display("FAIL arst_outputs m_valid=%b s_ready=%b exp=0,0", m_valid, s_ready); end
    checks++; if (sram_csb0 !== 1'b1 || sram_csb1 !== 1'b1) begin failures++; $display("FAIL arst_csb csb0=%b csb1=%b exp=1,1", sram_csb0, sram_csb1); end
    s_valid = 1'b0;
    @(negedge clk); rst = 1'b0;
    sb_q.delete();
    stray = 0;
    for (int c = 0; c < 3; c++) begin
      step(1'b0, 32'h0, 1'b1, 1'b0, acc, pop, md);
      if (m_valid !== 1'b0) stray++;
    end
    checks++; if (stray !== 0) begin failures++; $display("FAIL arst_empty stray_valid=%0d exp=0", stray); end
    checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL arst_s_ready got=%b exp=1", s_ready); end
    step(1'b1, 32'hA5A5_0001, 1'b1, 1'b0, acc, pop, md);
    if (acc) sb_q.push_back(32'hA5A5_0001);
    got = 0;
    for (int c = 0; c < 10 && got == 0; c++) begin
      step(1'b0, 32'h0, 1'b1, 1'b0, acc, pop, md);
      if (pop) begin
        logic [31:0] exp;
        exp = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hBAD0_BAD0;
        checks++; if (md !== exp) begin failures++; $display("FAIL arst_first_word got=%h exp=%h", md, exp); end
        got = 1;
      end
    end
    checks++; if (got !== 1) begin failures++; $display("FAIL arst_first_timeout got=%0d exp=1", got); end
    sb_q.delete();
  endtask

  initial begin
    checks = 0; failures = 0; collision_cnt = 0;
    test_reset();
    test_single();
    test_fill();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_async_reset();
    checks++; if (collision_cnt !== 0) begin failures++; $display("FAIL same_addr_total got=%0d exp=0", collision_cnt); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
